issue_ctrl: RTL

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - dual-issue scoreboard and issue control for a two-slot instruction buffer head
module issue_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       i_a_valid,
  input  logic       i_b_valid,
  input  logic [4:0] i_a_dest,
  input  logic [4:0] i_b_dest,
  input  logic [4:0] i_a_r1,
  input  logic [4:0] i_b_r1,
  input  logic [4:0] i_a_r2,
  input  logic [4:0] i_b_r2,
  input  logic       i_a_src2_is_imm,
  input  logic       i_b_src2_is_imm,
  input  logic       i_a_is_load,
  input  logic       i_a_is_mul,
  input  logic       i_a_is_div,
  input  logic       i_a_is_mem,
  input  logic       i_a_is_br,
  input  logic       i_a_is_serial,
  input  logic       i_b_is_load,
  input  logic       i_b_is_mul,
  input  logic       i_b_is_div,
  input  logic       i_b_is_mem,
  input  logic       i_b_is_br,
  input  logic       i_b_is_serial,
  input  logic       i_pipe_ready,
  input  logic       i_div_done,
  output logic [1:0] o_size,
  output logic       o_div_busy
);

  // Scoreboard encoding: 0 ready, 1..2 cycles left, 3 parked on the divider.
  localparam logic [1:0] CNT_READY = 2'd0;
  localparam logic [1:0] CNT_LOAD  = 2'd1;
  localparam logic [1:0] CNT_MUL   = 2'd2;
  localparam logic [1:0] CNT_DIV   = 2'd3;

  logic [1:0] cnt_q [32];
  logic [1:0] cnt_d [32];
  logic       div_busy_q;
  logic       div_busy_d;

  logic a_r1_ok, a_r2_ok, b_r1_ok, b_r2_ok;
  logic a_hazard_free, b_hazard_free;
  logic pair_conflict, raw_ab;
  logic issue_a, issue_b;
  logic [1:0] a_val, b_val;

  // A branch in slot b places no extra restriction on pairing.
  logic unused_b_is_br;
  assign unused_b_is_br = i_b_is_br;

  // Value written into the scoreboard for a newly issued producer; div wins over mul over load.
  function automatic logic [1:0] dest_cnt(input logic is_load, input logic is_mul,
                                          input logic is_div);
    if (is_div)       return CNT_DIV;
    else if (is_mul)  return CNT_MUL;
    else if (is_load) return CNT_LOAD;
    else              return CNT_READY;
  endfunction

  assign o_div_busy = div_busy_q;
  assign a_val      = dest_cnt(i_a_is_load, i_a_is_mul, i_a_is_div);
  assign b_val      = dest_cnt(i_b_is_load, i_b_is_mul, i_b_is_div);

  // Issue decision for both slots; reset and flush force a zero-size consume.
  always_comb begin
    a_r1_ok = (i_a_r1 == 5'd0) || (cnt_q[i_a_r1] == CNT_READY);
    a_r2_ok = i_a_src2_is_imm || (i_a_r2 == 5'd0) || (cnt_q[i_a_r2] == CNT_READY);
    b_r1_ok = (i_b_r1 == 5'd0) || (cnt_q[i_b_r1] == CNT_READY);
    b_r2_ok = i_b_src2_is_imm || (i_b_r2 == 5'd0) || (cnt_q[i_b_r2] == CNT_READY);
    a_hazard_free = a_r1_ok && a_r2_ok;
    b_hazard_free = b_r1_ok && b_r2_ok;

    pair_conflict = i_a_is_serial || i_b_is_serial || i_a_is_br
                 || (i_a_is_mem && i_b_is_mem)
                 || ((i_a_is_mul || i_a_is_div) && (i_b_is_mul || i_b_is_div))
                 || i_b_is_div;

    raw_ab = (i_a_dest != 5'd0)
          && ((i_a_dest == i_b_r1) || (!i_b_src2_is_imm && (i_a_dest == i_b_r2)));

    issue_a = !reset && !flush && i_a_valid && i_pipe_ready && a_hazard_free
           && !(i_a_is_div && div_busy_q);
    issue_b = issue_a && i_b_valid && b_hazard_free && !pair_conflict && !raw_ab;

    o_size = 2'd0;
    if (issue_b)      o_size = 2'd2;
    else if (issue_a) o_size = 2'd1;
  end

  // Scoreboard next state: age pending entries, then overlay new producers (slot b last).
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((cnt_q[i] == CNT_LOAD) || (cnt_q[i] == CNT_MUL)) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end else if ((cnt_q[i] == CNT_DIV) && i_div_done) begin
        cnt_d[i] = CNT_READY;
      end
    end
    if (issue_a && (i_a_dest != 5'd0)) cnt_d[i_a_dest] = a_val;
    if (issue_b && (i_b_dest != 5'd0)) cnt_d[i_b_dest] = b_val;
    if (flush) begin
      for (int i = 0; i < 32; i++) cnt_d[i] = CNT_READY;
    end
    cnt_d[0] = CNT_READY;
  end

  // Divider occupancy: a new div issue outranks a same-cycle completion.
  always_comb begin
    div_busy_d = div_busy_q;
    if (flush)                      div_busy_d = 1'b0;
    else if (issue_a && i_a_is_div) div_busy_d = 1'b1;
    else if (i_div_done)            div_busy_d = 1'b0;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= CNT_READY;
      div_busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      div_busy_q <= div_busy_d;
    end
  end

endmodule
